// File: rtl/fight_pkg.sv
// fight_pkg: shared types and constants for the round/match controller.
//   state_t        FSM encoding, also exported on fight_round_ctrl.state_o
//   NO_WINNER      winner code meaning "none yet" or "drawn match"
//   FRAMES_PER_SEC frame ticks per displayed second
package fight_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      FIGHT     = 3'd2,
      KO        = 3'd3,
      MATCH_END = 3'd4
   } state_t;

   localparam logic [2:0] NO_WINNER      = 3'd7;
   localparam int         FRAMES_PER_SEC = 60;

endpackage

// File: rtl/fight_round_ctrl_hp_channel.sv
// hp_channel: one fighter's health register with hit invulnerability.
//   Clk, Reset_n  clock, synchronous active-low reset
//   load          reload full health and clear invulnerability (round start)
//   tick_en       frame tick qualified by FIGHT; hits and invuln count only then
//   hit, heavy    hit level for this fighter, heavy selects double damage
//   health        registered health
//   health_nxt    value health takes at the next edge (used for KO adjudication)
//   is_zero       health_nxt == 0, so KO is seen on the same tick as the hit
module hp_channel #(
   parameter int HW            = 8,
   parameter int HEALTH_MAX    = 160,
   parameter int DAMAGE        = 8,
   parameter int INVULN_FRAMES = 20
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          load,
   input  logic          tick_en,
   input  logic          hit,
   input  logic          heavy,
   output logic [HW-1:0] health,
   output logic [HW-1:0] health_nxt,
   output logic          is_zero
);

   localparam int IW = $clog2(INVULN_FRAMES + 2);
   localparam int DW = HW + 1;
   localparam logic [HW-1:0] HP_FULL  = HW'(HEALTH_MAX);
   localparam logic [DW-1:0] DMG_LO   = DW'(DAMAGE);
   localparam logic [DW-1:0] DMG_HI   = DW'(2 * DAMAGE);
   localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_FRAMES);

   logic [IW-1:0] inv_q;
   logic [DW-1:0] dmg;
   logic          take;

   always_comb begin
      dmg        = heavy ? DMG_HI : DMG_LO;
      take       = tick_en & hit & (inv_q == '0);
      health_nxt = health;
      if (load)
         health_nxt = HP_FULL;
      else if (take)
         // one extra bit so a damage larger than health clamps to 0 instead of wrapping
         health_nxt = ({1'b0, health} > dmg) ? (health - dmg[HW-1:0]) : '0;
      is_zero = (health_nxt == '0);
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         health <= HP_FULL;
         inv_q  <= '0;
      end else begin
         health <= health_nxt;
         if (load)
            inv_q <= '0;
         else if (take)
            inv_q <= INV_LOAD;
         else if (tick_en && (inv_q != '0))
            inv_q <= inv_q - IW'(1);
      end
   end

endmodule

// File: rtl/fight_round_ctrl.sv
// fight_round_ctrl: best-of-K match sequencer for N fighters, advanced by frame_tick.
//   Clk, Reset_n   clock, synchronous active-low reset
//   frame_tick     one-cycle pulse per video frame; all sequencing steps on it
//   start          match start level, rising edge (sampled on ticks) qualifies
//   hit, heavy     per-fighter hit level and double-damage select
//   health         packed health, fighter i at [i*HW +: HW]
//   wins           packed 2-bit saturating round-win counts
//   fight_active   high only in FIGHT
//   round_num      1-based round, saturates at 15
//   secs_left      whole seconds remaining in the round
//   state_o        fight_pkg::state_t encoding
//   ko_pulse       one cycle after entering KO
//   winner         match winner index, NO_WINNER otherwise
//
// state     | meaning
// IDLE      | after reset, waiting for start
// COUNTDOWN | pre-fight "ready" delay, health and round timer loaded
// FIGHT     | hits applied, round timer running
// KO        | round awarded on entry, frozen for KO_FRAMES ticks
// MATCH_END | winner held until a fresh start edge
module fight_round_ctrl
   import fight_pkg::*;
#(
   parameter int N_FIGHTERS       = 2,
   parameter int HW               = 8,
   parameter int HEALTH_MAX       = 160,
   parameter int DAMAGE           = 8,
   parameter int INVULN_FRAMES    = 20,
   parameter int ROUND_FRAMES     = 5400,
   parameter int COUNTDOWN_FRAMES = 180,
   parameter int KO_FRAMES        = 120,
   parameter int ROUNDS_TO_WIN    = 2
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     frame_tick,
   input  logic                     start,
   input  logic [N_FIGHTERS-1:0]    hit,
   input  logic [N_FIGHTERS-1:0]    heavy,
   output logic [N_FIGHTERS*HW-1:0] health,
   output logic [N_FIGHTERS*2-1:0]  wins,
   output logic                     fight_active,
   output logic [3:0]               round_num,
   output logic [6:0]               secs_left,
   output logic [2:0]               state_o,
   output logic                     ko_pulse,
   output logic [2:0]               winner
);

   localparam logic [6:0]  SECS_INIT = 7'(ROUND_FRAMES / FRAMES_PER_SEC);
   localparam logic [5:0]  SUB_INIT  = 6'(ROUND_FRAMES % FRAMES_PER_SEC);
   localparam logic [5:0]  SUB_WRAP  = 6'(FRAMES_PER_SEC - 1);
   localparam logic [15:0] CD_LOAD   = 16'(COUNTDOWN_FRAMES - 1);
   localparam logic [15:0] KO_LOAD   = 16'(KO_FRAMES - 1);
   localparam logic [1:0]  WIN_TGT   = 2'(ROUNDS_TO_WIN);

   state_t         state_q, state_d;
   logic           start_q, start_rise;
   logic [15:0]    phase_q;
   logic [6:0]     sec_q;
   logic [5:0]     sub_q;
   logic [3:0]     round_q;
   logic [1:0]     wins_q [N_FIGHTERS];
   logic [2:0]     winner_q;
   logic           ko_q;

   logic [HW-1:0]  hp_q   [N_FIGHTERS];
   logic [HW-1:0]  hp_nxt [N_FIGHTERS];
   logic [N_FIGHTERS-1:0] hp_zero;

   logic           round_load, clear_match, next_round, phase_dec;
   logic           fight_tick, enter_ko, enter_end, timer_exp;
   logic [2:0]     n_alive;
   logic [HW-1:0]  best_hp;
   logic [1:0]     best_idx;
   logic           tie, award_ok;
   logic           match_won;
   logic [2:0]     match_idx;

   for (genvar g = 0; g < N_FIGHTERS; g++) begin : g_hp
      hp_channel #(
         .HW            (HW),
         .HEALTH_MAX    (HEALTH_MAX),
         .DAMAGE        (DAMAGE),
         .INVULN_FRAMES (INVULN_FRAMES)
      ) u_hp (
         .Clk        (Clk),
         .Reset_n    (Reset_n),
         .load       (round_load),
         .tick_en    (fight_tick),
         .hit        (hit[g]),
         .heavy      (heavy[g]),
         .health     (hp_q[g]),
         .health_nxt (hp_nxt[g]),
         .is_zero    (hp_zero[g])
      );
      assign health[g*HW +: HW] = hp_q[g];
      assign wins[g*2 +: 2]     = wins_q[g];
   end

   assign start_rise = start & ~start_q;
   // remaining frames = sec*60 + sub; this tick takes the last one
   assign timer_exp  = (sec_q == '0) && (sub_q == 6'd1);

   // Adjudication on post-hit health: unique maximum wins, but while others
   // are still standing it only counts if the clock ran out.
   always_comb begin
      n_alive  = '0;
      best_hp  = '0;
      best_idx = '0;
      tie      = 1'b1;
      for (int i = 0; i < N_FIGHTERS; i++) begin
         if (hp_nxt[i] != '0)
            n_alive = n_alive + 3'd1;
         if (hp_nxt[i] > best_hp) begin
            best_hp  = hp_nxt[i];
            best_idx = 2'(i);
            tie      = 1'b0;
         end else if (hp_nxt[i] == best_hp) begin
            tie = 1'b1;
         end
      end
      award_ok = !tie && ((n_alive == 3'd1) || timer_exp);
   end

   always_comb begin
      match_won = 1'b0;
      match_idx = NO_WINNER;
      for (int i = 0; i < N_FIGHTERS; i++) begin
         if (wins_q[i] >= WIN_TGT) begin
            match_won = 1'b1;
            match_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      round_load  = 1'b0;
      clear_match = 1'b0;
      next_round  = 1'b0;
      phase_dec   = 1'b0;
      fight_tick  = 1'b0;
      enter_ko    = 1'b0;
      enter_end   = 1'b0;
      if (frame_tick) begin
         case (state_q)
            IDLE, MATCH_END: begin
               if (start_rise) begin
                  state_d     = COUNTDOWN;
                  round_load  = 1'b1;
                  clear_match = 1'b1;
               end
            end
            COUNTDOWN: begin
               if (phase_q == '0)
                  state_d = FIGHT;
               else
                  phase_dec = 1'b1;
            end
            FIGHT: begin
               fight_tick = 1'b1;
               if ((|hp_zero) || timer_exp) begin
                  state_d  = KO;
                  enter_ko = 1'b1;
               end
            end
            KO: begin
               if (phase_q != '0) begin
                  phase_dec = 1'b1;
               end else if (match_won) begin
                  state_d   = MATCH_END;
                  enter_end = 1'b1;
               end else begin
                  state_d    = COUNTDOWN;
                  round_load = 1'b1;
                  next_round = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         start_q  <= 1'b0;
         phase_q  <= '0;
         sec_q    <= SECS_INIT;
         sub_q    <= SUB_INIT;
         round_q  <= 4'd1;
         winner_q <= NO_WINNER;
         ko_q     <= 1'b0;
         for (int i = 0; i < N_FIGHTERS; i++)
            wins_q[i] <= '0;
      end else begin
         ko_q <= enter_ko;
         if (frame_tick)
            start_q <= start;

         if (round_load) begin
            phase_q <= CD_LOAD;
            sec_q   <= SECS_INIT;
            sub_q   <= SUB_INIT;
         end else begin
            if (enter_ko)
               phase_q <= KO_LOAD;
            else if (phase_dec)
               phase_q <= phase_q - 16'd1;
            if (fight_tick) begin
               if (sub_q == '0) begin
                  sec_q <= sec_q - 7'd1;
                  sub_q <= SUB_WRAP;
               end else begin
                  sub_q <= sub_q - 6'd1;
               end
            end
         end

         if (clear_match) begin
            round_q  <= 4'd1;
            winner_q <= NO_WINNER;
         end else begin
            if (next_round && (round_q != 4'd15))
               round_q <= round_q + 4'd1;
            if (enter_end)
               winner_q <= match_idx;
         end

         for (int i = 0; i < N_FIGHTERS; i++) begin
            if (clear_match)
               wins_q[i] <= '0;
            else if (enter_ko && award_ok && (best_idx == 2'(i)) && (wins_q[i] != 2'd3))
               wins_q[i] <= wins_q[i] + 2'd1;
         end
      end
   end

   assign fight_active = (state_q == FIGHT);
   assign state_o      = state_q;
   assign round_num    = round_q;
   assign secs_left    = sec_q;
   assign ko_pulse     = ko_q;
   assign winner       = winner_q;

endmodule

// File: tb/tb_fight_round_ctrl.sv
module tb_fight_round_ctrl;

   localparam int N   = 2;
   localparam int HW  = 8;
   localparam int HM  = 160;
   localparam int INV = 20;
   localparam int RF  = 600;
   localparam int CD  = 12;
   localparam int KF  = 9;
   localparam int FPS = 60;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CD    = 3'd1;
   localparam logic [2:0] S_FIGHT = 3'd2;
   localparam logic [2:0] S_KO    = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;

   typedef struct packed {
      logic [2:0]  st;
      logic [3:0]  w;
      logic [15:0] hp;
      logic [3:0]  rn;
      logic [6:0]  sec;
   } ko_rec_t;

   logic          clk;
   logic          rst_n;
   logic          frame_tick;
   logic          start;
   logic [N-1:0]  hit;
   logic [N-1:0]  heavy;
   logic [N*HW-1:0] health;
   logic [N*2-1:0]  wins;
   logic          fight_active;
   logic [3:0]    round_num;
   logic [6:0]    secs_left;
   logic [2:0]    state_o;
   logic          ko_pulse;
   logic [2:0]    winner;

   int      n_cmp = 0;
   int      n_err = 0;
   int      fticks = 0;
   ko_rec_t ko_q[$];
   ko_rec_t exp_r, got_r;

   fight_round_ctrl #(
      .N_FIGHTERS       (N),
      .HW               (HW),
      .HEALTH_MAX       (HM),
      .DAMAGE           (8),
      .INVULN_FRAMES    (INV),
      .ROUND_FRAMES     (RF),
      .COUNTDOWN_FRAMES (CD),
      .KO_FRAMES        (KF),
      .ROUNDS_TO_WIN    (2)
   ) dut (
      .Clk          (clk),
      .Reset_n      (rst_n),
      .frame_tick   (frame_tick),
      .start        (start),
      .hit          (hit),
      .heavy        (heavy),
      .health       (health),
      .wins         (wins),
      .fight_active (fight_active),
      .round_num    (round_num),
      .secs_left    (secs_left),
      .state_o      (state_o),
      .ko_pulse     (ko_pulse),
      .winner       (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // KO scoreboard: every ko_pulse must match the next expected round result
   always @(negedge clk) begin
      if (ko_pulse === 1'b1) begin
         n_cmp++;
         if (ko_q.size() == 0) begin
            n_err++;
            $display("FAIL ko_scoreboard: ko_pulse seen with no KO expected (state %0d)", state_o);
         end else begin
            exp_r     = ko_q.pop_front();
            got_r.st  = state_o;
            got_r.w   = wins;
            got_r.hp  = health;
            got_r.rn  = round_num;
            got_r.sec = secs_left;
            if (got_r !== exp_r) begin
               n_err++;
               $display("FAIL ko_scoreboard: got st=%0d wins=%b hp=%h rn=%0d sec=%0d, want st=%0d wins=%b hp=%h rn=%0d sec=%0d",
                        got_r.st, got_r.w, got_r.hp, got_r.rn, got_r.sec,
                        exp_r.st, exp_r.w, exp_r.hp, exp_r.rn, exp_r.sec);
            end
         end
      end
   end

   task automatic push_ko(input logic [3:0] w, input logic [15:0] hp,
                          input logic [3:0] rn, input int frames_used);
      ko_rec_t r;
      r.st  = S_KO;
      r.w   = w;
      r.hp  = hp;
      r.rn  = rn;
      r.sec = 7'((RF - frames_used) / FPS);
      ko_q.push_back(r);
   endtask

   task automatic do_tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
      fticks++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic hit_once(input logic [N-1:0] h, input logic [N-1:0] hv);
      hit   = h;
      heavy = hv;
      do_tick();
      hit   = '0;
      heavy = '0;
      ticks(INV);
   endtask

   task automatic start_match();
      start = 1'b1;
      do_tick();
      start = 1'b0;
      n_cmp++;
      if (state_o !== S_CD || round_num !== 4'd1 || wins !== 4'b0) begin
         n_err++;
         $display("FAIL start_match: state=%0d rn=%0d wins=%b, want state=1 rn=1 wins=0000", state_o, round_num, wins);
      end
   endtask

   task automatic begin_round(input logic [3:0] exp_rn);
      ticks(CD - 1);
      n_cmp++;
      if (state_o !== S_CD) begin
         n_err++;
         $display("FAIL countdown_hold: state=%0d want 1", state_o);
      end
      do_tick();
      n_cmp++;
      if (state_o !== S_FIGHT || fight_active !== 1'b1 || round_num !== exp_rn) begin
         n_err++;
         $display("FAIL fight_entry: state=%0d active=%b rn=%0d, want 2 1 %0d", state_o, fight_active, round_num, exp_rn);
      end
      fticks = 0;
   endtask

   task automatic finish_ko(input logic [2:0] exp_st, input logic [3:0] exp_rn);
      ticks(KF - 1);
      n_cmp++;
      if (state_o !== S_KO || fight_active !== 1'b0) begin
         n_err++;
         $display("FAIL ko_hold: state=%0d active=%b, want 3 0", state_o, fight_active);
      end
      do_tick();
      n_cmp++;
      if (state_o !== exp_st || round_num !== exp_rn) begin
         n_err++;
         $display("FAIL ko_exit: state=%0d rn=%0d, want %0d %0d", state_o, round_num, exp_st, exp_rn);
      end
      if (exp_st == S_CD) begin
         n_cmp++;
         if (health !== {8'd160, 8'd160} || secs_left !== 7'(RF / FPS)) begin
            n_err++;
            $display("FAIL round_reload: hp=%h secs=%0d, want a0a0 %0d", health, secs_left, RF / FPS);
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      n_cmp++;
      if (state_o !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
      n_cmp++;
      if (health !== {8'd160, 8'd160}) begin n_err++; $display("FAIL reset_health: got %h want a0a0", health); end
      n_cmp++;
      if (wins !== 4'b0 || winner !== 3'd7) begin
         n_err++; $display("FAIL reset_wins: wins=%b winner=%0d want 0000 7", wins, winner);
      end
      n_cmp++;
      if (round_num !== 4'd1 || secs_left !== 7'(RF / FPS) || ko_pulse !== 1'b0 || fight_active !== 1'b0) begin
         n_err++;
         $display("FAIL reset_misc: rn=%0d secs=%0d ko=%b active=%b want 1 %0d 0 0", round_num, secs_left, ko_pulse, fight_active, RF / FPS);
      end
   endtask

   task automatic test_invuln();
      logic [7:0] want;
      start_match();
      begin_round(4'd1);
      hit = 2'b10;
      for (int k = 1; k <= 25; k++) begin
         do_tick();
         want = (k >= 22) ? 8'd144 : 8'd152;
         if (k == 1 || k == 2 || k == 21 || k == 22 || k == 25) begin
            n_cmp++;
            if (health[15:8] !== want || health[7:0] !== 8'd160) begin
               n_err++;
               $display("FAIL invuln_t%0d: hp1=%0d hp0=%0d want %0d 160", k, health[15:8], health[7:0], want);
            end
         end
      end
      hit = '0;
      n_cmp++;
      if (secs_left !== 7'((RF - 25) / FPS)) begin
         n_err++; $display("FAIL secs_after_25: got %0d want %0d", secs_left, (RF - 25) / FPS);
      end
   endtask

   task automatic test_reset_mid_fight();
      ticks(INV);
      for (int i = 0; i < 6; i++) begin
         if (i < 5) hit_once(2'b11, 2'b11);
         else       hit_once(2'b10, 2'b10);
      end
      hit_once(2'b10, 2'b00);
      n_cmp++;
      if (health !== {8'd40, 8'd80} || state_o !== S_FIGHT) begin
         n_err++; $display("FAIL pre_reset_hp: hp=%h state=%0d want 2850 2", health, state_o);
      end
      test_reset();
   endtask

   task automatic test_saturate_ko();
      start_match();
      begin_round(4'd1);
      for (int i = 0; i < 9; i++) hit_once(2'b01, 2'b01);
      hit_once(2'b01, 2'b00);
      n_cmp++;
      if (health[7:0] !== 8'd8) begin n_err++; $display("FAIL hp0_at_8: got %0d want 8", health[7:0]); end
      push_ko(4'b0100, {8'd160, 8'd0}, 4'd1, fticks + 1);
      hit = 2'b01; heavy = 2'b01;
      do_tick();
      hit = '0; heavy = '0;
      n_cmp++;
      if (state_o !== S_KO || health[7:0] !== 8'd0 || ko_pulse !== 1'b1) begin
         n_err++;
         $display("FAIL sat_ko_entry: state=%0d hp0=%0d ko=%b want 3 0 1", state_o, health[7:0], ko_pulse);
      end
      @(negedge clk);
      n_cmp++;
      if (ko_pulse !== 1'b0 || wins !== 4'b0100) begin
         n_err++; $display("FAIL ko_pulse_width: ko=%b wins=%b want 0 0100", ko_pulse, wins);
      end
      finish_ko(S_CD, 4'd2);
   endtask

   task automatic test_double_ko();
      begin_round(4'd2);
      for (int i = 0; i < 9; i++) hit_once(2'b11, 2'b11);
      hit_once(2'b11, 2'b00);
      push_ko(4'b0100, 16'h0000, 4'd2, fticks + 1);
      hit = 2'b11;
      do_tick();
      hit = '0;
      n_cmp++;
      if (state_o !== S_KO || wins !== 4'b0100) begin
         n_err++; $display("FAIL double_ko: state=%0d wins=%b want 3 0100", state_o, wins);
      end
      finish_ko(S_CD, 4'd3);
   endtask

   task automatic test_timeout();
      begin_round(4'd3);
      hit_once(2'b11, 2'b11);
      hit_once(2'b11, 2'b11);
      ticks(RF - 1 - fticks);
      n_cmp++;
      if (state_o !== S_FIGHT || secs_left !== 7'd0) begin
         n_err++; $display("FAIL timer_last_frame: state=%0d secs=%0d want 2 0", state_o, secs_left);
      end
      push_ko(4'b0100, {8'd128, 8'd128}, 4'd3, RF);
      do_tick();
      n_cmp++;
      if (state_o !== S_KO || wins !== 4'b0100) begin
         n_err++; $display("FAIL timeout_draw: state=%0d wins=%b want 3 0100", state_o, wins);
      end
      finish_ko(S_CD, 4'd4);

      begin_round(4'd4);
      hit_once(2'b10, 2'b10);
      hit_once(2'b10, 2'b10);
      ticks(RF - 1 - fticks);
      push_ko(4'b0101, {8'd128, 8'd160}, 4'd4, RF);
      do_tick();
      n_cmp++;
      if (state_o !== S_KO || wins !== 4'b0101 || secs_left !== 7'd0) begin
         n_err++; $display("FAIL timeout_win: state=%0d wins=%b secs=%0d want 3 0101 0", state_o, wins, secs_left);
      end
      finish_ko(S_CD, 4'd5);
   endtask

   task automatic test_match_end();
      test_reset();
      start_match();
      for (int r = 1; r <= 2; r++) begin
         begin_round(4'(r));
         for (int i = 0; i < 9; i++) hit_once(2'b10, 2'b10);
         push_ko(4'(r), {8'd0, 8'd160}, 4'(r), fticks + 1);
         hit = 2'b10; heavy = 2'b10;
         do_tick();
         hit = '0; heavy = '0;
         if (r == 1) finish_ko(S_CD, 4'd2);
      end
      start = 1'b1;
      finish_ko(S_END, 4'd2);
      n_cmp++;
      if (winner !== 3'd0 || fight_active !== 1'b0 || wins !== 4'b0010) begin
         n_err++; $display("FAIL match_end: winner=%0d active=%b wins=%b want 0 0 0010", winner, fight_active, wins);
      end
      ticks(3);
      n_cmp++;
      if (state_o !== S_END || winner !== 3'd0) begin
         n_err++; $display("FAIL start_held: state=%0d winner=%0d want 4 0", state_o, winner);
      end
      start = 1'b0;
      do_tick();
      n_cmp++;
      if (state_o !== S_END) begin n_err++; $display("FAIL start_low: state=%0d want 4", state_o); end
      start = 1'b1;
      do_tick();
      start = 1'b0;
      n_cmp++;
      if (state_o !== S_CD || wins !== 4'b0 || round_num !== 4'd1 || winner !== 3'd7) begin
         n_err++;
         $display("FAIL rematch: state=%0d wins=%b rn=%0d winner=%0d want 1 0000 1 7", state_o, wins, round_num, winner);
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      start      = 1'b0;
      hit        = '0;
      heavy      = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_invuln();
      test_reset_mid_fight();
      test_saturate_ko();
      test_double_ko();
      test_timeout();
      test_match_end();
      n_cmp++;
      if (ko_q.size() != 0) begin
         n_err++; $display("FAIL ko_missing: %0d expected KOs never seen, want 0", ko_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

endmodule
